// File: rtl/io_map_pkg.sv
// IO page map shared by the SoC IO peripherals.
// Word-address bits, UART status bits and UART TX FSM encoding.
package io_map_pkg;

  localparam int IO_LEDS_BIT         = 0;
  localparam int IO_SEG0_BIT         = 1;
  localparam int IO_SEG1_BIT         = 2;
  localparam int IO_UART_DATA_BIT    = 3;
  localparam int IO_UART_STATUS_BIT  = 4;

  localparam int ST_FULL_BIT = 0;
  localparam int ST_BUSY_BIT = 1;
  localparam int ST_OVF_BIT  = 2;

  typedef enum logic [3:0] {
    TX_IDLE  = 4'b0001,
    TX_START = 4'b0010,
    TX_DATA  = 4'b0100,
    TX_STOP  = 4'b1000
  } tx_state_t;

  // Pack the UART status flags into the 32-bit read word
  function automatic logic [31:0] status_word(
    input logic i_full,
    input logic i_busy,
    input logic i_ovf
  );
    logic [31:0] v;
    v = '0;
    v[ST_FULL_BIT] = i_full;
    v[ST_BUSY_BIT] = i_busy;
    v[ST_OVF_BIT]  = i_ovf;
    return v;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with first-word fall-through output.
// A push while full is taken when a pop happens in the same cycle.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == FULL_CNT);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the counter
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter on the IO page.
// DATA write queues a byte; STATUS read gives full/busy/overflow.
module uart_tx_io
  import io_map_pkg::*;
#(
  parameter int CLK_HZ     = 12_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_sel,
  input  logic [4:0]  io_word_addr,
  input  logic [7:0]  mem_wdata,
  input  logic        mem_wstrb,
  input  logic        mem_rstrb,
  output logic [31:0] io_rdata,
  output logic        tx,
  output logic        irq_empty
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

  tx_state_t   r_state;
  tx_state_t   w_state_nx;
  logic [BW-1:0] r_baud;
  logic [BW-1:0] w_baud_nx;
  logic [2:0]  r_bit;
  logic [2:0]  w_bit_nx;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_nx;
  logic        r_tx;
  logic        w_tx_nx;
  logic        r_ovf;
  logic        r_irq;
  logic [31:0] r_rdata;

  logic        w_push_req;
  logic        w_push;
  logic        w_pop;
  logic        w_ovf_evt;
  logic        w_st_rd;
  logic        w_busy;
  logic        w_baud_end;
  logic        w_full;
  logic        w_empty;
  logic [7:0]  w_dout;
  logic [CW-1:0] w_count;
  logic [31:0] w_status;
  logic [31:0] w_rd_word;

  assign w_push_req = io_sel & mem_wstrb &
                      io_word_addr[IO_UART_DATA_BIT];
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovf_evt  = w_push_req & w_full & ~w_pop;
  assign w_st_rd    = io_sel & mem_rstrb &
                      io_word_addr[IO_UART_STATUS_BIT];
  assign w_busy     = (w_count != '0) | (r_state != TX_IDLE);
  assign w_baud_end = (r_baud == BAUD_LAST);
  assign w_status   = status_word(w_full, w_busy,
                                  r_ovf | w_ovf_evt);

  assign io_rdata  = r_rdata;
  assign tx        = r_tx;
  assign irq_empty = r_irq;

  byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (mem_wdata),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Read word select; STATUS wins if several bits are set
  always_comb begin
    w_rd_word = '0;
    priority case (1'b1)
      io_word_addr[IO_UART_STATUS_BIT]: w_rd_word = w_status;
      io_word_addr[IO_UART_DATA_BIT]:   w_rd_word = '0;
      io_word_addr[IO_LEDS_BIT]:        w_rd_word = '0;
      io_word_addr[IO_SEG0_BIT]:        w_rd_word = '0;
      io_word_addr[IO_SEG1_BIT]:        w_rd_word = '0;
      default:                          w_rd_word = '0;
    endcase
  end

  // TX next state, baud/bit counters, shifter and line value
  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = r_baud;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_pop      = 1'b0;
    unique case (r_state)
      TX_IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_shift_nx = w_dout;
          w_baud_nx  = '0;
          w_bit_nx   = '0;
          w_state_nx = TX_START;
        end
      end
      TX_START: begin
        if (w_baud_end) begin
          w_baud_nx  = '0;
          w_state_nx = TX_DATA;
        end else begin
          w_baud_nx = r_baud + BW'(1);
        end
      end
      TX_DATA: begin
        if (w_baud_end) begin
          w_baud_nx  = '0;
          w_shift_nx = {1'b0, r_shift[7:1]};
          w_bit_nx   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_nx = TX_STOP;
        end else begin
          w_baud_nx = r_baud + BW'(1);
        end
      end
      TX_STOP: begin
        if (w_baud_end) begin
          w_baud_nx = '0;
          if (!w_empty) begin
            w_pop      = 1'b1;
            w_shift_nx = w_dout;
            w_bit_nx   = '0;
            w_state_nx = TX_START;
          end else begin
            w_state_nx = TX_IDLE;
          end
        end else begin
          w_baud_nx = r_baud + BW'(1);
        end
      end
      default: w_state_nx = TX_IDLE;
    endcase
    w_tx_nx = 1'b1;
    if (w_state_nx == TX_START) w_tx_nx = 1'b0;
    if (w_state_nx == TX_DATA)  w_tx_nx = w_shift_nx[0];
  end

  // TX state registers; line value registered with the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= TX_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_baud  <= w_baud_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_tx    <= w_tx_nx;
    end
  end

  // Sticky overflow, cleared by STATUS read unless set again
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_ovf <= 1'b0;
    else if (w_ovf_evt) r_ovf <= 1'b1;
    else if (w_st_rd)   r_ovf <= 1'b0;
  end

  // Registered read data and empty interrupt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
      r_irq   <= 1'b1;
    end else begin
      if (io_sel & mem_rstrb) r_rdata <= w_rd_word;
      r_irq <= w_empty & (r_state == TX_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_io.sv
// Scoreboard bench for uart_tx_io at DIV=12, depth 8.
// Line decoder pops expected bytes; read monitor pops expected status.
module tb_uart_tx_io;

  localparam int DIV   = 12;
  localparam int FRAME = 10 * DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        io_sel = 1'b0;
  logic [4:0]  io_word_addr = '0;
  logic [7:0]  mem_wdata = '0;
  logic        mem_wstrb = 1'b0;
  logic        mem_rstrb = 1'b0;
  logic [31:0] io_rdata;
  logic        tx;
  logic        irq_empty;

  uart_tx_io #(
    .CLK_HZ     (12_000_000),
    .BAUD       (1_000_000),
    .FIFO_DEPTH (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .io_sel       (io_sel),
    .io_word_addr (io_word_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_rstrb    (mem_rstrb),
    .io_rdata     (io_rdata),
    .tx           (tx),
    .irq_empty    (irq_empty)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_q[$];
  logic [31:0] rd_q[$];
  int          starts[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Line decoder and read-data monitor, sampled on falling edge
  bit         mbusy = 1'b0;
  int         mcnt = 0;
  logic       prev_tx = 1'b1;
  logic [7:0] mbyte = '0;
  bit         rd_pend = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      mbusy   = 1'b0;
      prev_tx = 1'b1;
      rd_pend = 1'b0;
    end else begin
      if (rd_pend) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("status_read", io_rdata, rd_q.pop_front());
      end
      rd_pend = io_sel & mem_rstrb;
      if (!mbusy) begin
        if (prev_tx === 1'b1 && tx === 1'b0) begin
          mbusy = 1'b1;
          mcnt  = 0;
          starts.push_back(cyc);
        end
      end else begin
        mcnt++;
      end
      if (mbusy && (mcnt % DIV) == DIV / 2) begin
        int k;
        k = mcnt / DIV;
        if (k == 0) begin
          chk("start_bit", 32'(tx), 0);
        end else if (k <= 8) begin
          mbyte[k-1] = tx;
        end else begin
          chk("stop_bit", 32'(tx), 1);
          if (exp_q.size() == 0) chk("frame_unexpected", 32'(mbyte), 32'hFFFF_FFFF);
          else chk("frame_byte", 32'(mbyte), 32'(exp_q.pop_front()));
          mbusy = 1'b0;
        end
      end
      prev_tx = tx;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    io_sel    = 1'b0;
    mem_wstrb = 1'b0;
    mem_rstrb = 1'b0;
    io_word_addr = '0;
  endtask

  task automatic drive_wr(input logic [7:0] b, input bit acc);
    io_sel       = 1'b1;
    mem_wstrb    = 1'b1;
    mem_rstrb    = 1'b0;
    io_word_addr = 5'b01000;
    mem_wdata    = b;
    if (acc) exp_q.push_back(b);
  endtask

  task automatic drive_rd(input logic [31:0] exp);
    io_sel       = 1'b1;
    mem_wstrb    = 1'b0;
    mem_rstrb    = 1'b1;
    io_word_addr = 5'b10000;
    rd_q.push_back(exp);
  endtask

  task automatic drive_wrrd(input logic [7:0] b,
                            input logic [31:0] exp);
    io_sel       = 1'b1;
    mem_wstrb    = 1'b1;
    mem_rstrb    = 1'b1;
    io_word_addr = 5'b11000;
    mem_wdata    = b;
    rd_q.push_back(exp);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_starts(input int n, input int budget);
    int i;
    i = 0;
    while (starts.size() < n && i < budget) begin
      step();
      i++;
    end
    chk("start_seen", 32'(starts.size() >= n), 1);
  endtask

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    while (!(irq_empty === 1'b1 && exp_q.size() == 0 && !mbusy)
           && i < budget) begin
      step();
      i++;
    end
    chk("drain", 32'(i < budget), 1);
  endtask

  // Fill from idle: first byte is popped at once, eight stay queued
  task automatic fill9();
    for (int i = 0; i < 9; i++) begin
      step();
      drive_wr(8'($urandom), 1'b1);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int s;
    int s2;
    int wr_cyc;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx), 1);
    chk("rst_rdata", io_rdata, 0);
    chk("rst_irq", 32'(irq_empty), 1);
    reset = 1'b0;
    repeat (2) step();

    // Single byte: start latency and bit pattern
    starts.delete();
    step();
    drive_wr(8'h55, 1'b1);
    wr_cyc = cyc + 1;
    step();
    drive_idle();
    wait_starts(1, 20);
    if (starts.size() > 0) chk("start_latency", 32'(starts[0] - wr_cyc), 1);
    wait_drain(FRAME + 40);
    chk("t1_frames", 32'(starts.size()), 1);
    chk("t1_tx_idle", 32'(tx), 1);

    // Two back-to-back frames, irq_empty one cycle after stop
    starts.delete();
    step();
    drive_wr(8'hA3, 1'b1);
    step();
    drive_wr(8'h0F, 1'b1);
    step();
    drive_idle();
    wait_starts(2, FRAME + 40);
    if (starts.size() >= 2) begin
      s2 = starts[1];
      chk("t2_gap", 32'(s2 - starts[0]), FRAME);
      wait_until(s2 + FRAME);
      chk("t2_irq_at_end", 32'(irq_empty), 0);
      step();
      chk("t2_irq_after", 32'(irq_empty), 1);
    end
    wait_drain(40);

    // Overflow: tenth byte dropped, status 7 then 3
    starts.delete();
    fill9();
    step();
    drive_wr(8'($urandom), 1'b0);
    step();
    drive_rd(32'h7);
    step();
    drive_rd(32'h3);
    step();
    drive_idle();
    wait_drain(9 * FRAME + 100);
    chk("t3_frames", 32'(starts.size()), 9);

    // Push while full on the STOP-end pop cycle is accepted
    starts.delete();
    fill9();
    step();
    drive_idle();
    wait_starts(1, 20);
    if (starts.size() > 0) begin
      s = starts[0];
      wait_until(s + FRAME - 1);
      drive_wr(8'($urandom), 1'b1);
      step();
      drive_rd(32'h3);
      step();
      drive_idle();
    end
    wait_drain(10 * FRAME + 100);
    chk("t4_frames", 32'(starts.size()), 10);

    // Reset during data bit 4 with three bytes queued
    starts.delete();
    step();
    drive_wr(8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      drive_wr(8'($urandom), 1'b1);
    end
    step();
    drive_idle();
    wait_starts(1, 20);
    if (starts.size() > 0) begin
      s = starts[0];
      wait_until(s + 5 * DIV + 4);
      #2;
      chk("t5_tx_before", 32'(tx), 0);
      reset = 1'b1;
      #1;
      chk("t5_tx_async", 32'(tx), 1);
      exp_q.delete();
      @(negedge clk);
      step();
      reset = 1'b0;
      starts.delete();
    end
    repeat (3 * FRAME) step();
    chk("t5_no_frame", 32'(starts.size()), 0);
    chk("t5_irq", 32'(irq_empty), 1);
    drive_rd(32'h0);
    step();
    drive_idle();
    step();

    // STATUS read on the overflow cycle keeps the flag for one more read
    fill9();
    step();
    drive_wrrd(8'($urandom), 32'h7);
    step();
    drive_rd(32'h7);
    step();
    drive_rd(32'h3);
    step();
    drive_idle();
    wait_drain(9 * FRAME + 100);

    // Random bursts that never exceed the buffering
    for (int n = 0; n < 6; n++) begin
      int len;
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) begin
        step();
        drive_wr(8'($urandom), 1'b1);
        if ($urandom_range(0, 3) == 0) begin
          step();
          drive_idle();
        end
      end
      step();
      drive_idle();
      wait_drain(len * FRAME + 100);
      step();
      drive_rd(32'h0);
      step();
      drive_idle();
    end

    repeat (4) step();
    chk("rd_q_empty", 32'(rd_q.size()), 0);
    chk("exp_q_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
